// File: rtl/async_fifo_rd_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_rd_serializer_if
// Brief    : FIFO read port plus narrow valid/ready beat stream of the serializer.
// Revision : 1.0
// ============================================================================
interface async_fifo_rd_serializer_if #(
   parameter int IN_WIDTH  = 64,
   parameter int OUT_WIDTH = 16
);
   logic                 fifo_rd_en_o;
   logic [IN_WIDTH-1:0]  fifo_rdata_i;
   logic                 fifo_rempty_i;
   logic                 m_valid_o;
   logic                 m_ready_i;
   logic [OUT_WIDTH-1:0] m_data_o;
   logic                 m_first_o;
   logic                 m_last_o;
   logic                 busy_o;

   modport master (
      output fifo_rd_en_o, m_valid_o, m_data_o, m_first_o, m_last_o, busy_o,
      input  fifo_rdata_i, fifo_rempty_i, m_ready_i
   );

   modport slave (
      input  fifo_rd_en_o, m_valid_o, m_data_o, m_first_o, m_last_o, busy_o,
      output fifo_rdata_i, fifo_rempty_i, m_ready_i
   );
endinterface
`default_nettype wire

// File: rtl/async_fifo_rd_serializer.sv
`default_nettype none
// ============================================================================
// Module   : async_fifo_rd_serializer
// Brief    : Pops wide show-ahead FIFO words and emits RATIO narrow beats each;
//            perf counters exist only with `ASYNC_FIFO_RD_PERF_EN defined.
// Revision : 1.0
// ============================================================================
module async_fifo_rd_serializer #(
   parameter int IN_WIDTH       = 64,
   parameter int OUT_WIDTH      = 16,
   parameter bit MSB_FIRST      = 1'b0,
   parameter int PERF_CNT_WIDTH = 16
) (
   input  wire logic                  clk_i,
   input  wire logic                  reset_i,
   async_fifo_rd_serializer_if.master bus
`ifdef ASYNC_FIFO_RD_PERF_EN
   ,
   output logic [PERF_CNT_WIDTH-1:0]  perf_stall_cnt_o,
   output logic [PERF_CNT_WIDTH-1:0]  perf_word_cnt_o
`endif
);

   localparam int               RATIO     = IN_WIDTH / OUT_WIDTH;
   localparam int               CNT_W     = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int               SLOTS     = 1 << CNT_W;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   state_t               state_q;
   logic [IN_WIDTH-1:0]  word_q;
   logic [CNT_W-1:0]     beat_q;
   logic                 valid_q;
   logic                 out_valid;
   logic                 is_last;
   logic                 accept;
   logic                 done;
   logic                 pop;
   logic [OUT_WIDTH-1:0] slice [SLOTS];

   generate
      if (OUT_WIDTH < 1 || OUT_WIDTH > IN_WIDTH || (IN_WIDTH % OUT_WIDTH) != 0 ||
          PERF_CNT_WIDTH < 1) begin : g_bad_cfg
         $error("async_fifo_rd_serializer: IN_WIDTH must be a multiple of OUT_WIDTH");
      end
   endgenerate

   // Slice table is padded to a power of two so beat_q indexes it exactly.
   genvar gi;
   generate
      for (gi = 0; gi < SLOTS; gi++) begin : g_slice
         if (gi < RATIO) begin : g_used
            if (MSB_FIRST) begin : g_msb
               assign slice[gi] = word_q[IN_WIDTH-1-gi*OUT_WIDTH -: OUT_WIDTH];
            end else begin : g_lsb
               assign slice[gi] = word_q[gi*OUT_WIDTH +: OUT_WIDTH];
            end
         end else begin : g_pad
            assign slice[gi] = '0;
         end
      end
   endgenerate

   assign valid_q   = (state_q == ST_SEND);
   assign out_valid = valid_q && !reset_i;
   assign is_last   = (beat_q == LAST_BEAT);
   assign accept    = out_valid && bus.m_ready_i;
   assign done      = accept && is_last;
   assign pop       = !reset_i && !bus.fifo_rempty_i && (!valid_q || done);

   assign bus.fifo_rd_en_o = pop;
   assign bus.m_valid_o    = out_valid;
   assign bus.busy_o       = out_valid;
   assign bus.m_data_o     = out_valid ? slice[beat_q] : '0;
   assign bus.m_first_o    = out_valid && (beat_q == '0);
   assign bus.m_last_o     = out_valid && is_last;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
         beat_q  <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (pop) begin
                  word_q  <= bus.fifo_rdata_i;
                  beat_q  <= '0;
                  state_q <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (done) begin
                  beat_q <= '0;
                  if (pop) begin
                     word_q <= bus.fifo_rdata_i;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else if (accept) begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

`ifdef ASYNC_FIFO_RD_PERF_EN
   logic [PERF_CNT_WIDTH-1:0] stall_cnt_q;
   logic [PERF_CNT_WIDTH-1:0] word_cnt_q;

   // Stall count saturates; word count wraps.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         stall_cnt_q <= '0;
         word_cnt_q  <= '0;
      end else begin
         if (out_valid && !bus.m_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
         if (pop) begin
            word_cnt_q <= word_cnt_q + 1'b1;
         end
      end
   end

   assign perf_stall_cnt_o = stall_cnt_q;
   assign perf_word_cnt_o  = word_cnt_q;
`endif

endmodule
`default_nettype wire
